// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - state encoding and fixed AR channel attributes
package axi_rd_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b11
   } state_t;

   // Single-beat, 32-bit, incrementing, modifiable/bufferable reads
   localparam logic [7:0] AR_LEN   = 8'd0;
   localparam logic [2:0] AR_SIZE  = 3'b010;
   localparam logic [1:0] AR_BURST = 2'b01;
   localparam logic       AR_LOCK  = 1'b0;
   localparam logic [3:0] AR_CACHE = 4'b0011;
   localparam logic [2:0] AR_PROT  = 3'b000;
   localparam logic [3:0] AR_QOS   = 4'b0000;
   localparam logic       AR_USER  = 1'b0;

   localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// rtl/axi_rd_arbiter_rr_arb2.sv - two-way round-robin grant with priority register
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       grant_en,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       gnt_idx
);

   logic prio_q;
   logic prio_d;

   always_comb begin
      gnt     = 2'b00;
      gnt_idx = 1'b0;
      prio_d  = prio_q;
      if (grant_en) begin
         if (req == 2'b11) begin
            gnt_idx = prio_q;
         end else begin
            gnt_idx = req[1];
         end
         if (|req) begin
            gnt    = gnt_idx ? 2'b10 : 2'b01;
            prio_d = ~gnt_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-requester single-beat AXI4 read arbiter
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH      = 32,
   parameter int C_M_AXI_DATA_WIDTH      = 32,
   parameter int C_M_AXI_THREAD_ID_WIDTH = 1
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               REQ0_VALID,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]      REQ0_ADDR,
   output logic                               REQ0_READY,
   input  logic                               REQ1_VALID,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]      REQ1_ADDR,
   output logic                               REQ1_READY,
   output logic                               RSP0_VALID,
   output logic [C_M_AXI_DATA_WIDTH-1:0]      RSP0_DATA,
   output logic                               RSP0_ERR,
   output logic                               RSP1_VALID,
   output logic [C_M_AXI_DATA_WIDTH-1:0]      RSP1_DATA,
   output logic                               RSP1_ERR,
   output logic                               BUSY,
   output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
   output logic [7:0]                         M_AXI_ARLEN,
   output logic [2:0]                         M_AXI_ARSIZE,
   output logic [1:0]                         M_AXI_ARBURST,
   output logic                               M_AXI_ARLOCK,
   output logic [3:0]                         M_AXI_ARCACHE,
   output logic [2:0]                         M_AXI_ARPROT,
   output logic [3:0]                         M_AXI_ARQOS,
   output logic [0:0]                         M_AXI_ARUSER,
   output logic                               M_AXI_ARVALID,
   input  logic                               M_AXI_ARREADY,
   input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
   input  logic [1:0]                         M_AXI_RRESP,
   input  logic                               M_AXI_RLAST,
   input  logic [0:0]                         M_AXI_RUSER,
   input  logic                               M_AXI_RVALID,
   output logic                               M_AXI_RREADY
);

   state_t                          state_q, state_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                            idx_q, idx_d;
   logic [1:0]                      rsp_valid_q, rsp_valid_d;
   logic [1:0]                      rsp_err_q, rsp_err_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data0_q, rsp_data0_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data1_q, rsp_data1_d;
   logic                            grant_en;
   logic [1:0]                      gnt;
   logic                            gnt_idx;
   logic                            r_done;
   logic                            unused_r;

   // Routing comes from the latched grant index, never from RID
   assign unused_r = ^{M_AXI_RID, M_AXI_RUSER};

   assign grant_en = (state_q == ST_IDLE);
   assign r_done   = (state_q == ST_DATA) && M_AXI_RVALID && M_AXI_RLAST;

   rr_arb2 u_rr_arb2 (
      .clk      (CLK),
      .rst      (RST),
      .grant_en (grant_en),
      .req      ({REQ1_VALID, REQ0_VALID}),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (|gnt)          state_d = ST_ADDR;
         ST_ADDR: if (M_AXI_ARREADY) state_d = ST_DATA;
         ST_DATA: if (r_done)        state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      addr_d      = addr_q;
      idx_d       = idx_q;
      rsp_valid_d = 2'b00;
      rsp_err_d   = rsp_err_q;
      rsp_data0_d = rsp_data0_q;
      rsp_data1_d = rsp_data1_q;
      if (|gnt) begin
         addr_d = gnt_idx ? REQ1_ADDR : REQ0_ADDR;
         idx_d  = gnt_idx;
      end
      if (r_done) begin
         rsp_valid_d[idx_q] = 1'b1;
         rsp_err_d[idx_q]   = (M_AXI_RRESP != RESP_OKAY);
         if (idx_q) begin
            rsp_data1_d = M_AXI_RDATA;
         end else begin
            rsp_data0_d = M_AXI_RDATA;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_q      <= '0;
         idx_q       <= 1'b0;
         rsp_valid_q <= 2'b00;
         rsp_err_q   <= 2'b00;
         rsp_data0_q <= '0;
         rsp_data1_q <= '0;
      end else begin
         addr_q      <= addr_d;
         idx_q       <= idx_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data0_q <= rsp_data0_d;
         rsp_data1_q <= rsp_data1_d;
      end
   end

   always_comb begin
      REQ0_READY    = gnt[0];
      REQ1_READY    = gnt[1];
      BUSY          = (state_q != ST_IDLE);
      M_AXI_ARVALID = (state_q == ST_ADDR);
      M_AXI_RREADY  = (state_q == ST_DATA);
      M_AXI_ARADDR  = addr_q;
      M_AXI_ARID    = C_M_AXI_THREAD_ID_WIDTH'(idx_q);
      RSP0_VALID    = rsp_valid_q[0];
      RSP1_VALID    = rsp_valid_q[1];
      RSP0_ERR      = rsp_err_q[0];
      RSP1_ERR      = rsp_err_q[1];
      RSP0_DATA     = rsp_data0_q;
      RSP1_DATA     = rsp_data1_q;
   end

   assign M_AXI_ARLEN   = AR_LEN;
   assign M_AXI_ARSIZE  = AR_SIZE;
   assign M_AXI_ARBURST = AR_BURST;
   assign M_AXI_ARLOCK  = AR_LOCK;
   assign M_AXI_ARCACHE = AR_CACHE;
   assign M_AXI_ARPROT  = AR_PROT;
   assign M_AXI_ARQOS   = AR_QOS;
   assign M_AXI_ARUSER  = AR_USER;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed transaction table plus reset corner sequences
module tb_axi_rd_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ0_VALID, REQ1_VALID;
   logic [31:0] REQ0_ADDR, REQ1_ADDR;
   logic        REQ0_READY, REQ1_READY;
   logic        RSP0_VALID, RSP1_VALID;
   logic [31:0] RSP0_DATA, RSP1_DATA;
   logic        RSP0_ERR, RSP1_ERR;
   logic        BUSY;
   logic [0:0]  ARID;
   logic [31:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARLOCK;
   logic [3:0]  ARCACHE;
   logic [2:0]  ARPROT;
   logic [3:0]  ARQOS;
   logic [0:0]  ARUSER;
   logic        ARVALID, ARREADY;
   logic [0:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic [0:0]  RUSER;
   logic        RVALID, RREADY;

   int total  = 0;
   int passed = 0;

   always #5 CLK = ~CLK;

   axi_rd_arbiter dut (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_READY(REQ0_READY),
      .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_READY(REQ1_READY),
      .RSP0_VALID(RSP0_VALID), .RSP0_DATA(RSP0_DATA), .RSP0_ERR(RSP0_ERR),
      .RSP1_VALID(RSP1_VALID), .RSP1_DATA(RSP1_DATA), .RSP1_ERR(RSP1_ERR),
      .BUSY(BUSY),
      .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN),
      .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARBURST(ARBURST), .M_AXI_ARLOCK(ARLOCK),
      .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARPROT(ARPROT), .M_AXI_ARQOS(ARQOS),
      .M_AXI_ARUSER(ARUSER), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
      .M_AXI_RID(RID), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
      .M_AXI_RLAST(RLAST), .M_AXI_RUSER(RUSER), .M_AXI_RVALID(RVALID),
      .M_AXI_RREADY(RREADY)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   typedef struct {
      bit          r0;
      bit          r1;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      int          stall;
      bit          beat;
      bit          exp_g;
   } vec_t;

   vec_t        vecs[9];
   logic [31:0] exp_data[2];
   bit          exp_err[2];
   bit          pend;
   bit          pend_port;
   logic [31:0] exp_addr;

   initial begin
      RST = 1'b1; REQ0_VALID = 0; REQ1_VALID = 0; REQ0_ADDR = 0; REQ1_ADDR = 0;
      ARREADY = 0; RID = 1'b1; RDATA = 0; RRESP = 0; RLAST = 0; RUSER = 0; RVALID = 0;
      exp_data[0] = 0; exp_data[1] = 0; exp_err[0] = 0; exp_err[1] = 0; pend = 0; pend_port = 0;

      vecs[0] = '{1, 0, 32'h1000, 32'h0,    32'hDEADBEEF, 2'b00, 0, 0, 0};
      vecs[1] = '{1, 1, 32'h2000, 32'h3004, 32'h11111111, 2'b00, 0, 0, 1};
      vecs[2] = '{1, 1, 32'h2008, 32'h300C, 32'h22222222, 2'b00, 0, 0, 0};
      vecs[3] = '{1, 1, 32'h2010, 32'h3014, 32'h33333333, 2'b00, 0, 1, 1};
      vecs[4] = '{0, 1, 32'h0,    32'h4000, 32'hCAFEF00D, 2'b10, 0, 0, 1};
      vecs[5] = '{1, 0, 32'h5000, 32'h0,    32'h0BADF00D, 2'b00, 5, 0, 0};
      vecs[6] = '{1, 1, 32'h6000, 32'h7000, 32'h12345678, 2'b11, 2, 1, 1};
      vecs[7] = '{0, 1, 32'h0,    32'h8000, 32'hA5A5A5A5, 2'b00, 0, 0, 1};
      vecs[8] = '{1, 1, 32'h9000, 32'h9004, 32'h5555AAAA, 2'b00, 1, 0, 0};

      repeat (3) @(negedge CLK);
      #1;
      check("rst_arvalid", ARVALID, 0);
      check("rst_rready", RREADY, 0);
      check("rst_busy", BUSY, 0);
      check("rst_rsp_valid", {RSP1_VALID, RSP0_VALID}, 0);
      check("rst_rsp_data", {RSP1_DATA, RSP0_DATA}, 0);
      check("rst_rsp_err", {RSP1_ERR, RSP0_ERR}, 0);
      check("ar_consts", {ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER},
            {8'd0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 1'b0});
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < 9; i++) begin
         @(negedge CLK);
         REQ0_VALID = vecs[i].r0; REQ1_VALID = vecs[i].r1;
         REQ0_ADDR = vecs[i].a0; REQ1_ADDR = vecs[i].a1;
         RVALID = 0; RLAST = 0;
         #1;
         if (pend) begin
            check("rsp_valid_route", {RSP1_VALID, RSP0_VALID}, pend_port ? 2'b10 : 2'b01);
            check("rsp_data0", RSP0_DATA, exp_data[0]);
            check("rsp_data1", RSP1_DATA, exp_data[1]);
            check("rsp_err", pend_port ? RSP1_ERR : RSP0_ERR, exp_err[pend_port]);
            pend = 0;
         end
         for (int n = 0; n < 8 && !(REQ0_READY || REQ1_READY); n++) begin
            @(negedge CLK);
            #1;
         end
         check("grant_seen", REQ0_READY || REQ1_READY, 1);
         check("grant_port", {REQ1_READY, REQ0_READY}, vecs[i].exp_g ? 2'b10 : 2'b01);
         exp_addr = vecs[i].exp_g ? vecs[i].a1 : vecs[i].a0;

         for (int k = 0; k <= vecs[i].stall; k++) begin
            @(negedge CLK);
            ARREADY = (k == vecs[i].stall);
            #1;
            check("arvalid", ARVALID, 1);
            check("araddr", ARADDR, exp_addr);
            check("arid", ARID, vecs[i].exp_g);
            check("no_ready_addr", {REQ1_READY, REQ0_READY}, 0);
            check("busy_addr", BUSY, 1);
            if (k == 0) begin
               check("rsp_one_cycle", {RSP1_VALID, RSP0_VALID}, 0);
               check("rsp_hold", {RSP1_DATA, RSP0_DATA}, {exp_data[1], exp_data[0]});
            end
         end

         if (vecs[i].beat) begin
            @(negedge CLK);
            ARREADY = 0; RVALID = 1; RLAST = 0; RDATA = 32'hBAD0BAD0; RRESP = 2'b10;
            #1;
            check("rready_beat", RREADY, 1);
            check("arvalid_low", ARVALID, 0);
         end
         @(negedge CLK);
         ARREADY = 0; RVALID = 1; RLAST = 1; RDATA = vecs[i].rdata; RRESP = vecs[i].rresp;
         RID = ~vecs[i].exp_g;
         #1;
         check("rready", RREADY, 1);
         check("no_ready_data", {REQ1_READY, REQ0_READY}, 0);
         check("no_rsp_early", {RSP1_VALID, RSP0_VALID}, 0);
         pend = 1;
         pend_port = vecs[i].exp_g;
         exp_data[pend_port] = vecs[i].rdata;
         exp_err[pend_port] = (vecs[i].rresp != 2'b00);
      end

      @(negedge CLK);
      REQ0_VALID = 0; REQ1_VALID = 0; RVALID = 0; RLAST = 0;
      #1;
      check("last_rsp_route", {RSP1_VALID, RSP0_VALID}, pend_port ? 2'b10 : 2'b01);
      check("last_rsp_data", pend_port ? RSP1_DATA : RSP0_DATA, exp_data[pend_port]);
      @(negedge CLK);
      #1;
      check("idle_busy", BUSY, 0);
      check("idle_rsp", {RSP1_VALID, RSP0_VALID}, 0);

      // Port 0 grant leaves priority on port 1; reset during DATA must restore port 0
      @(negedge CLK);
      REQ0_VALID = 1; REQ0_ADDR = 32'hC000;
      #1;
      check("int_grant", REQ0_READY, 1);
      @(negedge CLK);
      REQ0_VALID = 0; ARREADY = 1;
      #1;
      check("int_arvalid", ARVALID, 1);
      @(negedge CLK);
      ARREADY = 0; RVALID = 1; RLAST = 1; RDATA = 32'hFFFF0000; RRESP = 0; RST = 1;
      #1;
      check("int_rready", RREADY, 1);
      @(negedge CLK);
      RST = 0; RVALID = 0; RLAST = 0;
      #1;
      check("rst_mid_busy", BUSY, 0);
      check("rst_mid_rready", RREADY, 0);
      check("rst_mid_no_rsp", {RSP1_VALID, RSP0_VALID}, 0);
      check("rst_mid_data", {RSP1_DATA, RSP0_DATA}, 0);
      @(negedge CLK);
      REQ0_VALID = 1; REQ1_VALID = 1; REQ0_ADDR = 32'hA000; REQ1_ADDR = 32'hB000;
      #1;
      check("post_rst_prio", {REQ1_READY, REQ0_READY}, 2'b01);
      @(negedge CLK);
      REQ0_VALID = 0; REQ1_VALID = 0; ARREADY = 1;
      #1;
      check("post_rst_araddr", ARADDR, 32'hA000);
      check("post_rst_arid", ARID, 0);
      @(negedge CLK);
      ARREADY = 0; RVALID = 1; RLAST = 1; RDATA = 32'h5A5A5A5A; RRESP = 0;
      #1;
      @(negedge CLK);
      RVALID = 0; RLAST = 0;
      #1;
      check("post_rst_rsp", {RSP1_VALID, RSP0_VALID}, 2'b01);
      check("post_rst_data", RSP0_DATA, 32'h5A5A5A5A);
      check("post_rst_err", RSP0_ERR, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
